// File: rtl/people_controller_if.sv
// Elevator passenger-manager bundle: sim control and door events in,
// floor bitmaps and slot status out.
interface people_controller_if #(
  parameter int NUM_FLOORS = 12,
  parameter int MAX_PEOPLE = 4
);
  logic [1:0]            simState;
  logic [1:0]            simSpeed;
  logic [9:0]            randy;
  logic                  pickupValid;
  logic [4:0]            pickupFloor;
  logic                  dropValid;
  logic [4:0]            dropFloor;
  logic [NUM_FLOORS-1:0] floorsRequested;
  logic [NUM_FLOORS-1:0] floorDestinations;
  logic [4:0]            peopleGenerated;
  logic [MAX_PEOPLE-1:0] slotValid;
  logic                  spawnPulse;
  logic                  overflow;

  modport master (
    output simState, simSpeed, randy,
    output pickupValid, pickupFloor,
    output dropValid, dropFloor,
    input  floorsRequested, floorDestinations,
    input  peopleGenerated, slotValid,
    input  spawnPulse, overflow
  );

  modport slave (
    input  simState, simSpeed, randy,
    input  pickupValid, pickupFloor,
    input  dropValid, dropFloor,
    output floorsRequested, floorDestinations,
    output peopleGenerated, slotValid,
    output spawnPulse, overflow
  );
endinterface

// File: rtl/people_controller.sv
// Spawns passengers on a timer into a fixed slot pool and tracks them
// from waiting to riding to gone as the elevator opens its doors.
module people_controller #(
  parameter int NUM_FLOORS  = 12,
  parameter int MAX_PEOPLE  = 4,
  parameter int BASE_PERIOD = 64
) (
  input logic clk,
  input logic rst,
  people_controller_if.slave bus
);
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    RIDING  = 2'd2
  } slot_e;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_SIM   = 2'd1;
  localparam logic [1:0] ST_END   = 2'd3;

  slot_e       st_q  [MAX_PEOPLE];
  slot_e       st_d  [MAX_PEOPLE];
  logic [4:0]  src_q [MAX_PEOPLE];
  logic [4:0]  src_d [MAX_PEOPLE];
  logic [4:0]  dst_q [MAX_PEOPLE];
  logic [4:0]  dst_d [MAX_PEOPLE];
  logic [31:0] timer_q, timer_d;
  logic        ovf_q, ovf_d;
  logic        pulse_q, pulse_d;

  logic [31:0] period_m1;
  logic        sim, run, tick;
  logic        pick_ok, drop_ok;
  logic [4:0]  new_src, new_dst, d_raw;
  logic [MAX_PEOPLE-1:0] free_vec, spawn_sel;
  logic        any_free, found;

  always_comb begin
    period_m1 = (32'(BASE_PERIOD) << {~bus.simSpeed, 1'b0}) - 32'd1;
    sim  = bus.simState == ST_SIM;
    run  = sim || (bus.simState == ST_END);
    // >= so a speed-up past the current count ticks at once
    tick = sim && (timer_q >= period_m1);
    new_src = 5'({27'd0, bus.randy[4:0]} % 32'(NUM_FLOORS));
    d_raw   = 5'({27'd0, bus.randy[9:5]} % 32'(NUM_FLOORS));
    if (d_raw != new_src)
      new_dst = d_raw;
    else if (new_src == 5'(NUM_FLOORS - 1))
      new_dst = 5'd0;
    else
      new_dst = new_src + 5'd1;
    pick_ok = run && bus.pickupValid &&
              ({27'd0, bus.pickupFloor} < 32'(NUM_FLOORS));
    drop_ok = run && bus.dropValid &&
              ({27'd0, bus.dropFloor} < 32'(NUM_FLOORS));
  end

  always_comb begin
    found     = 1'b0;
    free_vec  = '0;
    spawn_sel = '0;
    for (int i = 0; i < MAX_PEOPLE; i++) begin
      free_vec[i]  = st_q[i] == FREE;
      spawn_sel[i] = free_vec[i] && !found;
      found        = found || free_vec[i];
    end
    any_free = found;
  end

  always_comb begin
    timer_d = timer_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    for (int i = 0; i < MAX_PEOPLE; i++) begin
      st_d[i]  = st_q[i];
      src_d[i] = src_q[i];
      dst_d[i] = dst_q[i];
    end
    if (bus.simState == ST_START) begin
      timer_d = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < MAX_PEOPLE; i++)
        st_d[i] = FREE;
    end else begin
      if (sim)
        timer_d = tick ? 32'd0 : timer_q + 32'd1;
      if (tick && !any_free)
        ovf_d = 1'b1;
      if (tick && any_free)
        pulse_d = 1'b1;
      // every decision below looks only at pre-edge slot state
      for (int i = 0; i < MAX_PEOPLE; i++) begin
        case (st_q[i])
          WAITING:
            if (pick_ok && src_q[i] == bus.pickupFloor)
              st_d[i] = RIDING;
          RIDING:
            if (drop_ok && dst_q[i] == bus.dropFloor)
              st_d[i] = FREE;
          default:
            if (tick && spawn_sel[i]) begin
              st_d[i]  = WAITING;
              src_d[i] = new_src;
              dst_d[i] = new_dst;
            end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      for (int i = 0; i < MAX_PEOPLE; i++) begin
        st_q[i]  <= FREE;
        src_q[i] <= '0;
        dst_q[i] <= '0;
      end
    end else begin
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < MAX_PEOPLE; i++) begin
        st_q[i]  <= st_d[i];
        src_q[i] <= src_d[i];
        dst_q[i] <= dst_d[i];
      end
    end
  end

  logic [NUM_FLOORS-1:0] req_map, dst_map;
  logic [MAX_PEOPLE-1:0] valid_map;
  logic [4:0]            count;

  always_comb begin
    req_map   = '0;
    dst_map   = '0;
    valid_map = '0;
    count     = '0;
    for (int i = 0; i < MAX_PEOPLE; i++) begin
      valid_map[i] = st_q[i] != FREE;
      if (st_q[i] != FREE)
        count = count + 5'd1;
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (st_q[i] == WAITING && src_q[i] == 5'(f))
          req_map[f] = 1'b1;
        if (st_q[i] == RIDING && dst_q[i] == 5'(f))
          dst_map[f] = 1'b1;
      end
    end
  end

  assign bus.floorsRequested   = req_map;
  assign bus.floorDestinations = dst_map;
  assign bus.peopleGenerated   = count;
  assign bus.slotValid         = valid_map;
  assign bus.spawnPulse        = pulse_q;
  assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_people_controller.sv
// Scoreboard bench: driver pushes model predictions per cycle,
// monitor pops and compares them after the corresponding edge.
module tb_people_controller;
  localparam int NF = 12;
  localparam int MP = 4;
  localparam int BP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  people_controller_if #(.NUM_FLOORS(NF), .MAX_PEOPLE(MP)) bus ();

  people_controller #(
    .NUM_FLOORS(NF), .MAX_PEOPLE(MP), .BASE_PERIOD(BP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int            tgt;
    logic [NF-1:0] fr;
    logic [NF-1:0] fd;
    logic [4:0]    pg;
    logic [MP-1:0] sv;
    logic          sp;
    logic          ov;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: people as (state, src, dst) records; 0 free, 1 waiting, 2 riding
  int m_st[MP];
  int m_src[MP];
  int m_dst[MP];
  int m_timer;
  bit m_ov, m_sp;

  task automatic model_clear();
    for (int i = 0; i < MP; i++) begin
      m_st[i] = 0; m_src[i] = 0; m_dst[i] = 0;
    end
    m_timer = 0; m_ov = 0; m_sp = 0;
  endtask

  task automatic step(int s, int spd, int ry, bit pv, int pf, bit dv, int df);
    int old[MP];
    int per, slot, src, d;
    bit tick;
    per  = BP << (2 * (3 - spd));
    tick = (s == 1) && (m_timer >= per - 1);
    old  = m_st;
    if (s == 0) begin
      model_clear();
      return;
    end
    m_sp = 0;
    if (s == 1 || s == 3)
      for (int i = 0; i < MP; i++) begin
        if (old[i] == 1 && pv && pf < NF && m_src[i] == pf)
          m_st[i] = 2;
        else if (old[i] == 2 && dv && df < NF && m_dst[i] == df)
          m_st[i] = 0;
      end
    if (s == 1) begin
      m_timer = tick ? 0 : m_timer + 1;
      if (tick) begin
        slot = -1;
        for (int i = 0; i < MP; i++)
          if (old[i] == 0 && slot < 0) slot = i;
        if (slot < 0) m_ov = 1;
        else begin
          src = (ry % 32) % NF;
          d   = ((ry / 32) % 32) % NF;
          m_st[slot]  = 1;
          m_src[slot] = src;
          m_dst[slot] = (d != src) ? d : (src + 1) % NF;
          m_sp = 1;
        end
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.tgt = 0; e.fr = '0; e.fd = '0; e.pg = '0; e.sv = '0;
    e.sp = m_sp; e.ov = m_ov;
    for (int i = 0; i < MP; i++) begin
      if (m_st[i] != 0) begin
        e.sv[i] = 1'b1;
        e.pg = e.pg + 5'd1;
      end
      if (m_st[i] == 1) e.fr[m_src[i]] = 1'b1;
      if (m_st[i] == 2) e.fd[m_dst[i]] = 1'b1;
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        e = q.pop_front();
        chk("floorsRequested", bus.floorsRequested, e.fr);
        chk("floorDestinations", bus.floorDestinations, e.fd);
        chk("peopleGenerated", bus.peopleGenerated, e.pg);
        chk("slotValid", bus.slotValid, e.sv);
        chk("spawnPulse", bus.spawnPulse, e.sp);
        chk("overflow", bus.overflow, e.ov);
      end
    end
  end

  // Called at posedge+1; drives one cycle of inputs and predicts its result
  task automatic drive(int s, int spd, int ry, bit pv, int pf, bit dv, int df);
    exp_t e;
    bus.simState    = 2'(s);
    bus.simSpeed    = 2'(spd);
    bus.randy       = 10'(ry);
    bus.pickupValid = pv;
    bus.pickupFloor = 5'(pf);
    bus.dropValid   = dv;
    bus.dropFloor   = 5'(df);
    step(s, spd, ry, pv, pf, dv, df);
    e = snap();
    e.tgt = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic sim_n(int n, int ry);
    for (int i = 0; i < n; i++) drive(1, 3, ry, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic zero_chk(string tag);
    chk({tag, ".fr"}, bus.floorsRequested, 0);
    chk({tag, ".fd"}, bus.floorDestinations, 0);
    chk({tag, ".pg"}, bus.peopleGenerated, 0);
    chk({tag, ".sv"}, bus.slotValid, 0);
    chk({tag, ".sp"}, bus.spawnPulse, 0);
    chk({tag, ".ov"}, bus.overflow, 0);
  endtask

  task automatic mid_reset(string tag);
    drain();
    #2 rst = 1'b1;
    #1 zero_chk(tag);
    @(posedge clk); #1;
    zero_chk({tag, "_edge"});
    rst = 1'b0;
    model_clear();
  endtask

  localparam int R92  = (9 << 5) | 2;
  localparam int R33  = (3 << 5) | 3;
  localparam int R11  = (11 << 5) | 11;
  localparam int R14  = (0 << 5) | 14;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, spd, ry, pf, df;
    bit pv, dv;
    rst = 1'b1;
    bus.simState = 2'd1; bus.simSpeed = 2'd3; bus.randy = 10'(R92);
    bus.pickupValid = 1'b0; bus.pickupFloor = '0;
    bus.dropValid = 1'b0; bus.dropFloor = '0;
    model_clear();
    #2 zero_chk("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // spawn cadence, fill, overflow, clear
    drive(0, 3, R92, 0, 0, 0, 0);
    sim_n(20, R92);
    drive(0, 3, R92, 0, 0, 0, 0);

    // destination wrap and modulo cases
    sim_n(4, R33);
    sim_n(4, R11);
    sim_n(4, R14);
    drive(0, 3, 0, 0, 0, 0, 0);

    // board / ride / alight, with same-cycle pickup+drop+spawn
    sim_n(4, R92);
    sim_n(3, R92);
    drive(1, 3, R92, 1, 2, 1, 9);
    drive(1, 3, R92, 1, 2, 0, 0);
    drive(3, 3, R92, 0, 0, 1, 9);
    drive(0, 3, 0, 0, 0, 0, 0);

    // pause ignores pickup and freezes timer
    sim_n(2, R92);
    drive(2, 3, R92, 0, 0, 0, 0);
    sim_n(2, R92);
    drive(2, 3, R92, 1, 2, 0, 0);
    drive(1, 3, R92, 1, 2, 0, 0);
    drive(1, 0, R92, 0, 0, 0, 0);
    drive(1, 3, R92, 0, 0, 0, 0);

    // three people then async reset
    drive(0, 3, 0, 0, 0, 0, 0);
    sim_n(12, R33);
    mid_reset("rst_mid");

    for (int c = 0; c < 800; c++) begin
      if (c == 400) mid_reset("rst_rand");
      s = $urandom_range(0, 99);
      s = (s < 80) ? 1 : (s < 88) ? 2 : (s < 98) ? 3 : 0;
      spd = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(0, 3);
      ry = $urandom_range(0, 1023);
      pv = $urandom_range(0, 1);
      dv = $urandom_range(0, 1);
      pf = $urandom_range(0, 15);
      df = $urandom_range(0, 15);
      for (int i = 0; i < MP; i++) begin
        if (m_st[i] == 1 && $urandom_range(0, 1) == 1) pf = m_src[i];
        if (m_st[i] == 2 && $urandom_range(0, 1) == 1) df = m_dst[i];
      end
      drive(s, spd, ry, pv, pf, dv, df);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/people_controller.md
PEOPLE_CONTROLLER -- requirements
Module: people_controller

Interface
REQ-001 Parameter NUM_FLOORS, default 12: floor count; legal range 2..32.
REQ-002 Parameter MAX_PEOPLE, default 4: passenger slot count; legal range 1..16.
REQ-003 Parameter BASE_PERIOD, default 64: spawn interval in cycles at fastest speed; legal range >=2.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 simState  in  2  00 START, 01 SIM, 10 PAUSE, 11 ENDING.
REQ-007 simSpeed  in  2  spawn rate select, 00 slowest to 11 fastest.
REQ-008 randy  in  10  free-running random word, sampled on spawn cycles only.
REQ-009 pickupValid  in  1  elevator opened doors for boarding this cycle.
REQ-010 pickupFloor  in  5  floor index for pickupValid.
REQ-011 dropValid  in  1  elevator opened doors for alighting this cycle.
REQ-012 dropFloor  in  5  floor index for dropValid.
REQ-013 floorsRequested  out  NUM_FLOORS  bit f = 1 iff any WAITING slot has source floor f.
REQ-014 floorDestinations  out  NUM_FLOORS  bit f = 1 iff any RIDING slot has destination floor f.
REQ-015 peopleGenerated  out  5  count of non-FREE slots.
REQ-016 slotValid  out  MAX_PEOPLE  bit i = 1 iff slot i is not FREE.
REQ-017 spawnPulse  out  1  one-cycle pulse when a person is created.
REQ-018 overflow  out  1  sticky; set when a spawn is dropped because all slots are occupied.

Function
REQ-019 Each slot SHALL hold state FREE/WAITING/RIDING, src[4:0] and dst[4:0].
REQ-020 The spawn timer SHALL count only while simState==SIM; period P = BASE_PERIOD << (2*(3-simSpeed)), so 11 gives BASE_PERIOD and 00 gives 64*BASE_PERIOD.
REQ-021 When the timer reaches P-1 it SHALL wrap to 0 and raise a spawn tick that same cycle; a simSpeed change SHALL take effect on the next compare, and a timer value already >= the new P-1 SHALL tick and wrap immediately.
REQ-022 On a spawn tick the block SHALL compute src = randy[4:0] mod NUM_FLOORS and d = randy[9:5] mod NUM_FLOORS; dst = d if d != src, else (src+1) mod NUM_FLOORS.
REQ-023 On a spawn tick with a FREE slot, the lowest-index FREE slot SHALL become WAITING with src/dst loaded; spawnPulse SHALL be 1 in the following cycle only.
REQ-024 On a spawn tick with no FREE slot, no slot SHALL change; overflow SHALL set and hold until rst or START.
REQ-025 In SIM, pickupValid SHALL move every WAITING slot whose src==pickupFloor to RIDING in one cycle.
REQ-026 In SIM, dropValid SHALL move every RIDING slot whose dst==dropFloor to FREE in one cycle.
REQ-027 Pickup, drop and spawn in the same cycle SHALL all evaluate pre-edge slot state: a slot boarded this cycle is not dropped this cycle, and a newly spawned slot is not boarded this cycle.
REQ-028 A spawn SHALL NOT reuse a slot freed by a drop in the same cycle; a FREE slot is usable only from the next cycle.
REQ-029 pickupFloor/dropFloor >= NUM_FLOORS SHALL be ignored.
REQ-030 START SHALL synchronously clear all slots to FREE, the timer to 0, overflow to 0 and spawnPulse to 0.
REQ-031 PAUSE SHALL freeze timer and slots and ignore pickup/drop; the resumed SIM continues from the frozen timer value.
REQ-032 ENDING SHALL freeze the timer and spawns but still honour pickup/drop, so the sim can drain.
REQ-033 All outputs except spawnPulse and overflow SHALL be combinational decodes of slot registers; the bitmaps and count therefore change one cycle after the causing event.

Reset
REQ-034 On rst all slots SHALL be FREE, the timer 0 and overflow 0; all outputs SHALL read 0 while rst is high, independent of clk.
REQ-035 Reset asserted mid-operation SHALL discard every in-flight person, with no partial update on the deasserting edge.

Verification
REQ-036 BASE_PERIOD=4, simSpeed=11, SIM, randy={5'd9,5'd2} -> spawnPulse every 4th cycle; first spawn gives floorsRequested bit2=1, peopleGenerated=1.
REQ-037 randy={5'd3,5'd3} -> slot dst=4; randy={5'd11,5'd11} with NUM_FLOORS=12 -> dst=0; randy src field 5'd14 -> src=2.
REQ-038 Spawn 5 people with MAX_PEOPLE=4 -> peopleGenerated=4, overflow=1 after the 5th tick; START -> all zero.
REQ-039 Person src=2/dst=9: pickupValid floor 2 -> next cycle floorsRequested[2]=0, floorDestinations[9]=1; dropValid floor 9 -> slot FREE, count decrements.
REQ-040 Same cycle as pickup floor 2, also assert dropValid floor 9 and a spawn tick with src=2 -> person 1 becomes RIDING (not dropped), new person is WAITING at 2.
REQ-041 Assert rst mid-sim with 3 people -> outputs 0 immediately; in PAUSE, a pickup on an occupied floor -> no change.
